cdb_arbiter: RTL

- Consumer end of the functional-unit result handshake.
- Collects completed results from N execute-stage functional units (add/sub, branch, load-address, etc.).
- Each unit holds valid_out and its CDB_packet_t until it sees yumi_in.
- The arbiter selects one unit per cycle round-robin, returns its yumi, and drives the registered result onto the Common Data Bus (CDB) for the ROB and reservation stations.

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/cdb_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared result packet carried from functional units onto the Common Data Bus.
package cdb_arbiter_pkg;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  dest_ROB_entry;
        logic        branch_result;
        logic        load_step1;
    } CDB_packet_t;

endpackage

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin consumer of functional-unit results, driving one
// registered broadcast per cycle onto the Common Data Bus.
// Optional: define CDB_STATS_EN to add bcast_count / conflict_count outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_FU = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_FU-1:0]        fu_valid,
    input  CDB_packet_t [N_FU-1:0] fu_pkt,
    output logic [N_FU-1:0]        fu_yumi,
    input  logic                   cdb_stall,
    input  logic                   flush,
    output logic                   cdb_valid,
    output CDB_packet_t            cdb_pkt
`ifdef CDB_STATS_EN
    ,
    output logic [31:0]            bcast_count,
    output logic [31:0]            conflict_count
`endif
);

    localparam int PTR_W = $clog2(N_FU);
    localparam logic [PTR_W:0] N_FU_W = (PTR_W+1)'(N_FU);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_next;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;
    logic             grant;
    logic             slot_free;
    logic [PTR_W:0]   scan_pos;

    // A held broadcast blocks the slot only while the ROB is stalling it.
    assign slot_free = !cdb_valid || !cdb_stall;
    assign grant     = reset && !flush && slot_free && grant_found;
    assign rr_next   = (grant_idx == PTR_W'(N_FU-1)) ? '0 : grant_idx + 1'b1;

    // Search requesters starting at rr_ptr, wrapping past the last unit.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_pos    = '0;
        for (int k = 0; k < N_FU; k++) begin
            scan_pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_pos >= N_FU_W) begin
                scan_pos = scan_pos - N_FU_W;
            end
            if (!grant_found && fu_valid[scan_pos[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_pos[PTR_W-1:0];
            end
        end
    end

    // Consume strobes: flush drains every pending unit, otherwise one-hot grant.
    always_comb begin
        fu_yumi = '0;
        if (!reset) begin
            fu_yumi = '0;
        end else if (flush) begin
            fu_yumi = fu_valid;
        end else if (grant) begin
            fu_yumi = N_FU'(1) << grant_idx;
        end
    end

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_pkt   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (slot_free) begin
            if (grant) begin
                cdb_valid <= 1'b1;
                cdb_pkt   <= fu_pkt[grant_idx];
                rr_ptr    <= rr_next;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

`ifdef CDB_STATS_EN
    // Broadcast and contention counters; cleared only by reset, never by flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcast_count    <= '0;
            conflict_count <= '0;
        end else begin
            if (grant) begin
                bcast_count <= bcast_count + 32'd1;
            end
            if (slot_free && ($countones(fu_valid) > 1)) begin
                conflict_count <= conflict_count + 32'd1;
            end
        end
    end
`endif

endmodule
